// File: rtl/sfifo_pkg.sv
`default_nettype none
// ============================================================================
// Package : sfifo_pkg
// Shared widths, error-status type and parameter checks for sfifo_flagged.
// Revision: 1.0
// ============================================================================
package sfifo_pkg;

    // Occupancy/pointer width: enough bits for 0..depth inclusive.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_t;

    function automatic bit levels_legal(input int depth, input int af, input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae < depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfifo_mem.sv
`default_nettype none
// ============================================================================
// Module  : sfifo_mem
// Storage array: one synchronous write port, one read port that is
// combinational, or registered when SFIFO_OUTPUT_REG_EN is defined.
// Revision: 1.0
// ============================================================================
module sfifo_mem
    import sfifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int POINTER_WIDTH = 3
) (
    input  logic                     clk,
`ifdef SFIFO_OUTPUT_REG_EN
    input  logic                     rst,
    input  logic                     re,
`endif
    input  logic                     we,
    input  logic [POINTER_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [POINTER_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int DATA_NUM = 2**POINTER_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DATA_NUM];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef SFIFO_OUTPUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`else
    assign rdata = mem[raddr];
`endif

endmodule
`default_nettype wire

// File: rtl/sfifo_flagged.sv
`default_nettype none
// ============================================================================
// Module  : sfifo_flagged
// Single-clock FIFO with fill count, almost-full/empty thresholds, flush and
// sticky overflow/underflow. Macro SFIFO_OUTPUT_REG_EN registers data_out.
// Revision: 1.0
// ============================================================================
module sfifo_flagged
    import sfifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int POINTER_WIDTH = 3,
    parameter int AF_LEVEL      = (2**POINTER_WIDTH) - 2,
    parameter int AE_LEVEL      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic                   rd,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [POINTER_WIDTH:0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int DATA_NUM = 2**POINTER_WIDTH;
    localparam int CNT_W    = ptr_w(DATA_NUM);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_NUM);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    if (!levels_legal(DATA_NUM, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
        $error("sfifo_flagged: AF_LEVEL or AE_LEVEL out of legal range");
    end

    if (CNT_W != POINTER_WIDTH + 1) begin : g_bad_width
        $error("sfifo_flagged: pointer width mismatch");
    end

    logic [CNT_W-1:0] w_ptr;
    logic [CNT_W-1:0] r_ptr;
    logic [CNT_W-1:0] count_q;
    err_t             err_q;
    logic             we;
    logic             re;

    // Accepts use only registered flags, so wr/rd never reach status outputs.
    assign we = wr & ~fifo_full  & ~flush;
    assign re = rd & ~fifo_empty & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            count_q <= '0;
            err_q   <= '0;
        end else begin
            if (we) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (re) begin
                r_ptr <= r_ptr + 1'b1;
            end
            case ({we, re})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            err_q.overflow  <= err_q.overflow  | (wr & fifo_full);
            err_q.underflow <= err_q.underflow | (rd & fifo_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q == w_ptr - r_ptr);
        end
    end

    assign count        = count_q;
    assign fifo_full    = (count_q == FULL_CNT);
    assign fifo_empty   = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

    sfifo_mem #(
        .DATA_WIDTH    (DATA_WIDTH),
        .POINTER_WIDTH (POINTER_WIDTH)
    ) u_mem (
        .clk   (clk),
`ifdef SFIFO_OUTPUT_REG_EN
        .rst   (rst),
        .re    (re),
`endif
        .we    (we),
        .waddr (w_ptr[POINTER_WIDTH-1:0]),
        .wdata (data_in),
        .raddr (r_ptr[POINTER_WIDTH-1:0]),
        .rdata (data_out)
    );

endmodule
`default_nettype wire
